// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch-side and memory-controller-side signals of the instruction cache.
interface icache_direct_if;
  logic [31:0] IC_addr;
  logic        IC_addr_sgn;
  logic        rollback;
  logic        IC_ins_sgn;
  logic [31:0] IC_ins;
  logic        mc_valid;
  logic [31:0] mc_addr;
  logic        mc_ready;
  logic [31:0] mc_data;
  modport slave (
    input  IC_addr, IC_addr_sgn, rollback, mc_ready, mc_data,
    output IC_ins_sgn, IC_ins, mc_valid, mc_addr
  );
  modport master (
    output IC_addr, IC_addr_sgn, rollback, mc_ready, mc_data,
    input  IC_ins_sgn, IC_ins, mc_valid, mc_addr
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with word-by-word line refill.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt lookup counters.
module icache_direct #(
  parameter int INDEX_W = 6,
  parameter int OFFSET_W = 2,
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, RESP, REFILL} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0] data_mem [LINES << OFFSET_W];
  logic ins_sgn_q, ins_sgn_d, mc_valid_q, mc_valid_d;
  logic [31:0] ins_q, ins_d, mc_addr_q, mc_addr_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d, off;
  logic [INDEX_W-1:0] idx, rf_idx;
  logic [TAG_W-1:0] tag, rf_tag;
  logic hit, lookup, data_we, tag_we;
  logic [1:0] unused_byte;
  assign idx = bus.IC_addr[INDEX_W+OFFSET_W+1 -: INDEX_W];
  assign off = bus.IC_addr[OFFSET_W+1 -: OFFSET_W];
  assign tag = bus.IC_addr[31 -: TAG_W];
  assign unused_byte = bus.IC_addr[1:0];
  // mc_addr never leaves the line being refilled, so its upper fields identify that line
  assign rf_idx = mc_addr_q[INDEX_W+OFFSET_W+1 -: INDEX_W];
  assign rf_tag = mc_addr_q[31 -: TAG_W];
  assign hit = valid_q[idx] && tag_mem[idx] == tag;
  assign lookup = rdy && state_q == IDLE && !bus.rollback && !bus.IC_addr_sgn;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ins_sgn_d = ins_sgn_q;
    ins_d = ins_q;
    mc_valid_d = mc_valid_q;
    mc_addr_d = mc_addr_q;
    cnt_d = cnt_q;
    data_we = 1'b0;
    tag_we = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (lookup && hit) begin
            ins_d = data_mem[{idx, off}];
            ins_sgn_d = 1'b1;
            state_d = RESP;
          end else if (lookup) begin
            mc_valid_d = 1'b1;
            mc_addr_d = {bus.IC_addr[31:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
            cnt_d = '0;
            valid_d[idx] = 1'b0;
            state_d = REFILL;
          end
        end
        RESP: begin
          ins_sgn_d = 1'b0;
          state_d = IDLE;
        end
        REFILL: begin
          if (bus.mc_ready) begin
            data_we = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
              mc_addr_d = mc_addr_q + 32'd4;
            end else begin
              valid_d[rf_idx] = 1'b1;
              tag_we = 1'b1;
              mc_valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      ins_sgn_q <= 1'b0;
      ins_q <= '0;
      mc_valid_q <= 1'b0;
      mc_addr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ins_sgn_q <= ins_sgn_d;
      ins_q <= ins_d;
      mc_valid_q <= mc_valid_d;
      mc_addr_q <= mc_addr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (data_we) data_mem[{rf_idx, cnt_q}] <= bus.mc_data;
    if (tag_we) tag_mem[rf_idx] <= rf_tag;
  end
  assign bus.IC_ins_sgn = ins_sgn_q;
  assign bus.IC_ins = ins_q;
  assign bus.mc_valid = mc_valid_q;
  assign bus.mc_addr = mc_addr_q;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  assign hit_cnt_d = lookup && hit ? hit_cnt_q + 32'd1 : hit_cnt_q;
  assign miss_cnt_d = lookup && !hit ? miss_cnt_q + 32'd1 : miss_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: table-driven and randomized checks of icache_direct against a line-level model.
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  icache_direct_if bus();
  icache_direct dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave));
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit m_valid [64];
  logic [21:0] m_tag [64];

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    logic [31:0] ins;
    int          rb;
    int          frz;
  } vec_t;
  vec_t tbl [11];

  // backing memory: word k of line L holds (L << 8) | (k+1)*0x11
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return ((w >> 4) << 8) | ((((w >> 2) & 32'd3) + 32'd1) * 32'h11);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] base, input int rb_word, input int frz_word, input bit rnd);
    int gap;
    int idx;
    for (int w = 0; w < 4; w++) begin
      chk("refill_addr", bus.mc_addr, base + 32'(4 * w));
      chk("refill_valid", {31'd0, bus.mc_valid}, 32'd1);
      gap = rnd ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.mc_ready = 1'b0;
        bus.IC_addr = $urandom;
        bus.IC_addr_sgn = 1'($urandom_range(0, 1));
        step;
        chk("gap_addr", bus.mc_addr, base + 32'(4 * w));
        chk("gap_no_resp", {31'd0, bus.IC_ins_sgn}, 32'd0);
      end
      bus.mc_ready = 1'b1;
      bus.mc_data = mem(base + 32'(4 * w));
      bus.rollback = (w == rb_word) || (rnd && $urandom_range(0, 3) == 0);
      if (w == frz_word) begin
        rdy = 1'b0;
        repeat (3) begin
          step;
          chk("frz_addr", bus.mc_addr, base + 32'(4 * w));
          chk("frz_valid", {31'd0, bus.mc_valid}, 32'd1);
        end
        rdy = 1'b1;
      end
      step;
      bus.mc_ready = 1'b0;
      bus.rollback = 1'b0;
      chk("refill_no_resp", {31'd0, bus.IC_ins_sgn}, 32'd0);
    end
    chk("refill_done", {31'd0, bus.mc_valid}, 32'd0);
    idx = int'((base >> 4) % 64);
    m_valid[idx] = 1'b1;
    m_tag[idx] = base[31:10];
  endtask

  task automatic access(input logic [31:0] a, input int rb_word, input int frz_word, input bit rnd,
                        output bit hit, output logic [31:0] ins);
    int idx;
    bit exp_hit;
    idx = int'((a >> 4) % 64);
    exp_hit = m_valid[idx] && m_tag[idx] == a[31:10];
    bus.IC_addr = a;
    bus.IC_addr_sgn = 1'b0;
    bus.rollback = 1'b0;
    step;
    hit = bus.IC_ins_sgn;
    ins = bus.IC_ins;
    bus.IC_addr_sgn = 1'b1;
    if (exp_hit) begin
      chk("hit_pulse", {31'd0, bus.IC_ins_sgn}, 32'd1);
      chk("hit_data", bus.IC_ins, mem(a));
      chk("hit_no_req", {31'd0, bus.mc_valid}, 32'd0);
      step;
      chk("bubble", {31'd0, bus.IC_ins_sgn}, 32'd0);
    end else begin
      chk("miss_no_resp", {31'd0, bus.IC_ins_sgn}, 32'd0);
      refill(a & 32'hFFFF_FFF0, rb_word, frz_word, rnd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    logic [31:0] ins;
    logic [31:0] a;
    tbl[0]  = '{32'h0000_0000, 1'b0, 32'h0,      -1, -1};
    tbl[1]  = '{32'h0000_0000, 1'b1, 32'h11,     -1, -1};
    tbl[2]  = '{32'h0000_0004, 1'b1, 32'h22,     -1, -1};
    tbl[3]  = '{32'h0000_0008, 1'b1, 32'h33,     -1, -1};
    tbl[4]  = '{32'h0000_0400, 1'b0, 32'h0,      -1, -1};
    tbl[5]  = '{32'h0000_0400, 1'b1, 32'h4011,   -1, -1};
    tbl[6]  = '{32'h0000_0000, 1'b0, 32'h0,      -1, -1};
    tbl[7]  = '{32'h0000_0040, 1'b0, 32'h0,       1, -1};
    tbl[8]  = '{32'h0000_0044, 1'b1, 32'h422,    -1, -1};
    tbl[9]  = '{32'h0000_0800, 1'b0, 32'h0,      -1,  2};
    tbl[10] = '{32'h0000_0808, 1'b1, 32'h8033,   -1, -1};
    bus.IC_addr = '0;
    bus.IC_addr_sgn = 1'b1;
    bus.rollback = 1'b0;
    bus.mc_ready = 1'b0;
    bus.mc_data = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
    chk("rst_ins", bus.IC_ins, 32'd0);
    chk("rst_mc_valid", {31'd0, bus.mc_valid}, 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'd0);
    step;
    rst = 1'b1;
    step;
    chk("idle_no_req", {31'd0, bus.mc_valid}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      access(tbl[i].addr, tbl[i].rb, tbl[i].frz, 1'b0, h, ins);
      chk("tbl_hit", {31'd0, h}, {31'd0, tbl[i].hit});
      if (tbl[i].hit) chk("tbl_ins", ins, tbl[i].ins);
    end

    // reset in the middle of a refill of line 0xC00
    bus.IC_addr = 32'h0000_0C00;
    bus.IC_addr_sgn = 1'b0;
    step;
    bus.IC_addr_sgn = 1'b1;
    chk("mid_miss_req", {31'd0, bus.mc_valid}, 32'd1);
    for (int w = 0; w < 2; w++) begin
      bus.mc_ready = 1'b1;
      bus.mc_data = mem(32'h0000_0C00 + 32'(4 * w));
      step;
    end
    bus.mc_ready = 1'b0;
    chk("mid_addr", bus.mc_addr, 32'h0000_0C08);
    #2 rst = 1'b0;
    #1;
    chk("async_mc_valid", {31'd0, bus.mc_valid}, 32'd0);
    chk("async_mc_addr", bus.mc_addr, 32'd0);
    chk("async_ins", bus.IC_ins, 32'd0);
    chk("async_sgn", {31'd0, bus.IC_ins_sgn}, 32'd0);
    step;
    rst = 1'b1;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    access(32'h0000_0C04, -1, -1, 1'b0, h, ins);
    chk("rst_refill_miss", {31'd0, h}, 32'd0);
    access(32'h0000_0C04, -1, -1, 1'b0, h, ins);
    chk("rst_refill_hit", {31'd0, h}, 32'd1);

    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        bus.IC_addr = a;
        bus.IC_addr_sgn = 1'($urandom_range(0, 1));
        bus.rollback = bus.IC_addr_sgn ? 1'($urandom_range(0, 1)) : 1'b1;
        step;
        chk("suppress_no_resp", {31'd0, bus.IC_ins_sgn}, 32'd0);
        chk("suppress_no_req", {31'd0, bus.mc_valid}, 32'd0);
        bus.rollback = 1'b0;
      end
      access(a, -1, $urandom_range(0, 9), 1'b1, h, ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the memory controller and the instruction-fetch stage.
- Serves 32-bit instruction words to fetch: one registered response pulse per accepted address.
- On a miss, refills a whole line word-by-word through a simple request/ready memory-controller port.
- Honours rollback (flush) from the ROB and the global rdy pause.

Parameters:
- INDEX_W, 6, line-index bits (64 lines).
- OFFSET_W, 2, word-offset bits within a line (4 words = 16 bytes per line).
- TAG_W, 32-INDEX_W-OFFSET_W-2, tag width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low = freeze all state.
- IC_addr  in  32  fetch address, word aligned (bits [1:0] ignored).
- IC_addr_sgn  in  1  fetch stalled; 1 = no request this cycle.
- rollback  in  1  flush from ROB.
- IC_ins_sgn  out  1  response valid, one-cycle pulse.
- IC_ins  out  32  instruction word, valid while IC_ins_sgn=1.
- mc_valid  out  1  refill word request to memory controller.
- mc_addr  out  32  word-aligned refill address.
- mc_ready  in  1  one-cycle pulse; mc_data valid.
- mc_data  in  32  returned word.

Behaviour:
- Storage: valid[2^INDEX_W], tag[2^INDEX_W], data[2^(INDEX_W+OFFSET_W)] x 32.
- Address split: index = addr[INDEX_W+OFFSET_W+1 : OFFSET_W+2], offset = addr[OFFSET_W+1 : 2], tag = upper TAG_W bits.
- Reset (rst=0, async):
  - All valid bits cleared; state=IDLE.
  - IC_ins_sgn=0, IC_ins=0, mc_valid=0, mc_addr=0, refill counter=0.
  - Data and tag arrays need not be reset.
- rdy=0: every register holds, including mc_valid/mc_addr. mc_ready is ignored while rdy=0; the controller keeps mc_ready high until rdy=1.
- Priority each cycle: rst > !rdy > FSM.
- IDLE:
  - rollback=1 or IC_addr_sgn=1: no lookup; stay IDLE.
  - Otherwise look up IC_addr combinationally.
  - Hit: IC_ins<=word, IC_ins_sgn<=1, go to RESP. Latency = 1 cycle from address to pulse.
  - Miss: latch line base (IC_addr with offset and byte bits zeroed), counter<=0, mc_valid<=1, mc_addr<=base, clear valid[index], go to REFILL.
- RESP:
  - IC_ins_sgn<=0; go to IDLE.
  - This mandatory bubble gives fetch one edge to advance its PC, so the same address is never answered twice.
  - Maximum throughput: 1 instruction per 2 cycles.
- REFILL:
  - mc_valid stays 1 until mc_ready.
  - On mc_ready: data[index][counter]<=mc_data.
  - If counter < 2^OFFSET_W-1: counter++, mc_addr+=4, mc_valid stays 1.
  - Else: valid[index]<=1, tag[index]<=latched tag, mc_valid<=0, go to IDLE. The next IDLE lookup of the same address hits.
  - No response is issued directly from REFILL.
- rollback:
  - In IDLE: suppresses the lookup.
  - In RESP: no effect; the pulse ends anyway.
  - In REFILL: the refill runs to completion and the line is installed.
  - Fetch ignores IC_ins_sgn during rollback.
- Address change during REFILL: ignored; handled by the IDLE lookup afterwards.
- mc_addr wraps at 32 bits (no special handling).
- The line becomes valid only after the last word arrives. A refill interrupted by reset leaves the line invalid.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt (32) and miss_cnt (32), both reset to 0.
  - hit_cnt increments on every IDLE lookup that hits; miss_cnt increments on every IDLE lookup that misses.
  - Neither counter changes while rdy=0 or on suppressed lookups.
  - Both wrap at 2^32.
- Undefined: no counters and no extra ports; all other behaviour identical.

Test Plan:
- Cold miss at 0x00000000 → mc_addr sequence 0x0, 0x4, 0x8, 0xC; mc_valid drops after the 4th mc_ready. Next cycle IDLE hit → IC_ins_sgn=1 with the word returned at 0x0.
- Fill line 0x0–0xC with 0x11,0x22,0x33,0x44, then addresses 0x4, 0x8 → pulses carrying 0x22 then 0x33, each separated by exactly one idle cycle. No mc_valid.
- Conflict: access 0x400 after line 0x0 is resident (same index, tag differs) → miss, refill from 0x400. A subsequent access to 0x0 misses again.
- rollback=1 in the cycle of the 2nd mc_ready during refill of 0x40 → refill continues to 0x4C; no IC_ins_sgn during refill. Afterwards 0x44 hits.
- rdy=0 for 3 cycles while mc_valid=1 with mc_ready held high → mc_addr and counter frozen. Capture happens only after rdy returns to 1.
- Assert rst=0 mid-refill → outputs zero immediately (async). After release, the partially filled address misses and refills.
